vga_sync_sr_driver: RTL and testbench



---
 rtl/vga_sync_sr_driver_if.sv | 17 +
 rtl/vga_sync_sr_driver.sv | 97 +++++++++
 tb/tb_vga_sync_sr_driver.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_sr_driver_if.sv
// vga_sync_sr_driver_if: raster control and timing bundle between the sync driver and its consumers
// Signals: enable (consumer -> driver); hs_s, hs_r, vs_s, vs_r set/reset pulses, de, x, y, frame_start (driver -> consumer)
interface vga_sync_sr_driver_if #(
  parameter int CNT_W = 11
);
  logic             enable;
  logic             hs_s;
  logic             hs_r;
  logic             vs_s;
  logic             vs_r;
  logic             de;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             frame_start;
  modport master (input enable, output hs_s, hs_r, vs_s, vs_r, de, x, y, frame_start);
  modport slave  (output enable, input hs_s, hs_r, vs_s, vs_r, de, x, y, frame_start);
endinterface

// File: rtl/vga_sync_sr_driver.sv
// vga_sync_sr_driver: raster counters emitting registered set/reset pulses for external HSYNC/VSYNC SR flip-flops
// Ports: clk_i pixel clock; rst_n_i async active-low reset;
//        bus (master): enable in; hs_s/hs_r/vs_s/vs_r pulses, de, x, y, frame_start out (all 1 CLK after the counter state they decode)
// Option: define VGA_SR_SYNC_ACTIVE_LOW_EN to swap the S/R roles on both channels so downstream Q idles high
module vga_sync_sr_driver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CNT_W    = 11
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  vga_sync_sr_driver_if.master bus
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = (HS_START + H_SYNC) % H_TOTAL;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = (VS_START + V_SYNC) % V_TOTAL;
  // ST_INIT lasts exactly one edge after reset release and emits the pulse that defines the reset-less downstream flip-flops
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
  logic de_q, de_d, fs_q, fs_d;
  logic hs_s_q, hs_s_d, hs_r_q, hs_r_d, vs_s_q, vs_s_d, vs_r_q, vs_r_d;
  logic en, init, h_last, v_last, line0, hs_on, hs_off, vs_on, vs_off;
  always_comb begin
    en      = bus.enable;
    init    = state_q == ST_INIT;
    state_d = ST_RUN;
    h_last  = h_q == CNT_W'(H_TOTAL - 1);
    v_last  = v_q == CNT_W'(V_TOTAL - 1);
    line0   = h_q == '0;
    h_d     = en ? (h_last ? '0 : h_q + 1'b1) : h_q;
    v_d     = (en && h_last) ? (v_last ? '0 : v_q + 1'b1) : v_q;
    de_d    = en && h_q < CNT_W'(H_ACTIVE) && v_q < CNT_W'(V_ACTIVE);
    x_d     = de_d ? h_q : '0;
    y_d     = de_d ? v_q : '0;
    fs_d    = en && line0 && v_q == '0;
    hs_on   = en && h_q == CNT_W'(HS_START);
    hs_off  = en && h_q == CNT_W'(HS_END);
    vs_on   = en && line0 && v_q == CNT_W'(VS_START);
    vs_off  = en && line0 && v_q == CNT_W'(VS_END);
`ifdef VGA_SR_SYNC_ACTIVE_LOW_EN
    hs_s_d  = hs_off || init;
    hs_r_d  = hs_on;
    vs_s_d  = vs_off || init;
    vs_r_d  = vs_on;
`else
    hs_s_d  = hs_on;
    hs_r_d  = hs_off || init;
    vs_s_d  = vs_on;
    vs_r_d  = vs_off || init;
`endif
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_INIT;
      h_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      hs_s_q  <= 1'b0;
      hs_r_q  <= 1'b0;
      vs_s_q  <= 1'b0;
      vs_r_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      x_q     <= x_d;
      y_q     <= y_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      hs_s_q  <= hs_s_d;
      hs_r_q  <= hs_r_d;
      vs_s_q  <= vs_s_d;
      vs_r_q  <= vs_r_d;
    end
  end
  assign bus.hs_s        = hs_s_q;
  assign bus.hs_r        = hs_r_q;
  assign bus.vs_s        = vs_s_q;
  assign bus.vs_r        = vs_r_q;
  assign bus.de          = de_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_sync_sr_driver.sv
// tb_vga_sync_sr_driver: default-timing and small-timing drivers checked against a pixel-index raster model
module tb_vga_sync_sr_driver;
  localparam int HA [2] = '{640, 4};
  localparam int HF [2] = '{16, 1};
  localparam int HS [2] = '{96, 2};
  localparam int HB [2] = '{48, 1};
  localparam int VA [2] = '{480, 3};
  localparam int VF [2] = '{10, 1};
  localparam int VS [2] = '{2, 1};
  localparam int VB [2] = '{33, 1};
`ifdef VGA_SR_SYNC_ACTIVE_LOW_EN
  localparam bit LOW = 1'b1;
`else
  localparam bit LOW = 1'b0;
`endif
  typedef struct packed {
    logic        hs_s, hs_r, vs_s, vs_r, de, fs;
    logic [10:0] x, y;
  } out_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   mp0, mp1;
  bit   minit;
  out_t exp0, exp1, act0, act1;
  always #5 clk = ~clk;
  vga_sync_sr_driver_if #(.CNT_W(11)) bus0 ();
  vga_sync_sr_driver_if #(.CNT_W(11)) bus1 ();
  vga_sync_sr_driver #(
    .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
    .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]), .CNT_W(11)
  ) dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus0));
  vga_sync_sr_driver #(
    .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
    .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]), .CNT_W(11)
  ) dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus1));
  assign act0 = {bus0.hs_s, bus0.hs_r, bus0.vs_s, bus0.vs_r, bus0.de, bus0.frame_start, bus0.x, bus0.y};
  assign act1 = {bus1.hs_s, bus1.hs_r, bus1.vs_s, bus1.vs_r, bus1.de, bus1.frame_start, bus1.x, bus1.y};
  function automatic int htot(int k);
    return HA[k] + HF[k] + HS[k] + HB[k];
  endfunction
  function automatic int vtot(int k);
    return VA[k] + VF[k] + VS[k] + VB[k];
  endfunction
  function automatic out_t mk(bit hs_s, bit hs_r, bit vs_s, bit vs_r, bit de, bit fs, int x, int y);
    return {hs_s, hs_r, vs_s, vs_r, de, fs, 11'(x), 11'(y)};
  endfunction
  // p is the linear pixel index within the frame; outputs are what one edge with enable en produces from it
  function automatic out_t model(int k, int p, bit en, bit init);
    int h = p % htot(k);
    int v = p / htot(k);
    bit de = en && h < HA[k] && v < VA[k];
    bit hon = en && h == HA[k] + HF[k];
    bit hoff = en && h == (HA[k] + HF[k] + HS[k]) % htot(k);
    bit von = en && h == 0 && v == VA[k] + VF[k];
    bit voff = en && h == 0 && v == (VA[k] + VF[k] + VS[k]) % vtot(k);
    return mk(LOW ? (hoff || init) : hon, LOW ? hon : (hoff || init),
              LOW ? (voff || init) : von, LOW ? von : (voff || init),
              de, en && p == 0, de ? h : 0, de ? v : 0);
  endfunction
  task automatic chk_o(string name, out_t a, out_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask
  task automatic chk_i(string name, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mp0   <= 0;
      mp1   <= 0;
      minit <= 1'b1;
      exp0  <= '0;
      exp1  <= '0;
    end else begin
      exp0  <= model(0, mp0, bus0.enable, minit);
      exp1  <= model(1, mp1, bus1.enable, minit);
      if (bus0.enable) mp0 <= (mp0 + 1) % (htot(0) * vtot(0));
      if (bus1.enable) mp1 <= (mp1 + 1) % (htot(1) * vtot(1));
      minit <= 1'b0;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk_o("dut0_out", act0, exp0);
      chk_o("dut1_out", act1, exp1);
      chk_i("dut0_hs_s_and_r", int'(act0.hs_s & act0.hs_r), 0);
      chk_i("dut0_vs_s_and_r", int'(act0.vs_s & act0.vs_r), 0);
      chk_i("dut1_hs_s_and_r", int'(act1.hs_s & act1.hs_r), 0);
      chk_i("dut1_vs_s_and_r", int'(act1.vs_s & act1.vs_r), 0);
    end
  end
  initial begin
    int on_at[$];
    int off_at[$];
    int de_run, de_max, de_line, hq, vq, hcnt, vcnt, g;
    bus0.enable = 1'b0;
    bus1.enable = 1'b0;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1 chk_o("reset_out0", act0, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus0.enable = 1'b1;
    bus1.enable = 1'b1;
    @(posedge clk);
    de_run = 0; de_max = 0; de_line = 0; hq = 0; vq = 0; hcnt = 0; vcnt = 0;
    for (int n = 0; n < 2500; n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk_o("init_edge0", act0, mk(LOW, !LOW, LOW, !LOW, 1'b1, 1'b1, 0, 0));
        chk_o("init_edge1", act1, mk(LOW, !LOW, LOW, !LOW, 1'b1, 1'b1, 0, 0));
      end
      if (LOW ? act0.hs_r : act0.hs_s) on_at.push_back(n);
      if (n > 0 && (LOW ? act0.hs_s : act0.hs_r)) off_at.push_back(n);
      de_run = act0.de ? de_run + 1 : 0;
      if (de_run > de_max) de_max = de_run;
      if (n < 800 && act0.de) de_line++;
      if (n < 144) begin
        hq = act1.hs_s ? 1 : act1.hs_r ? 0 : hq;
        vq = act1.vs_s ? 1 : act1.vs_r ? 0 : vq;
        if (hq != int'(LOW)) hcnt++;
        if (vq != int'(LOW)) vcnt++;
      end
    end
    chk_i("hs_on_count", on_at.size(), 3);
    chk_i("hs_off_count", off_at.size(), 3);
    chk_i("hs_on_first", on_at.size() > 0 ? on_at[0] : -1, 656);
    chk_i("hs_on_period", on_at.size() > 1 ? on_at[1] - on_at[0] : -1, 800);
    chk_i("hs_sync_width", (on_at.size() > 0 && off_at.size() > 0) ? off_at[0] - on_at[0] : -1, 96);
    chk_i("de_run_max", de_max, 640);
    chk_i("de_first_line", de_line, 640);
    chk_i("small_hsync_cycles", hcnt, 36);
    chk_i("small_vsync_cycles", vcnt, 24);
    for (g = 0; g < 10000 && mp0 != 8300; g++) begin
      @(posedge clk);
      #2 bus1.enable = $urandom_range(0, 3) != 0;
    end
    chk_i("reach_h300_v10", mp0, 8300);
    bus0.enable = 1'b0;
    @(negedge clk);
    chk_i("pre_hold_x", int'(act0.x), 299);
    chk_i("pre_hold_y", int'(act0.y), 10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_i("hold_de", int'(act0.de), 0);
      chk_i("hold_x", int'(act0.x), 0);
    end
    bus0.enable = 1'b1;
    @(negedge clk);
    chk_o("resume_x300", act0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 300, 10));
    for (g = 0; g < 1000 && mp0 % 800 != 301; g++) begin
      @(posedge clk);
      #2 bus1.enable = $urandom_range(0, 3) != 0;
    end
    chk_i("reach_mid_line", mp0 % 800, 301);
    rst_n = 1'b0;
    #1;
    chk_o("async_clear0", act0, '0);
    chk_o("async_clear1", act1, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus1.enable = 1'b1;
    @(negedge clk);
    chk_o("pre_init0", act0, '0);
    @(negedge clk);
    chk_o("reinit0", act0, mk(LOW, !LOW, LOW, !LOW, 1'b1, 1'b1, 0, 0));
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus0.enable = 1'b0;
    bus1.enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_o("init_no_enable0", act0, mk(LOW, !LOW, LOW, !LOW, 1'b0, 1'b0, 0, 0));
    chk_o("init_no_enable1", act1, mk(LOW, !LOW, LOW, !LOW, 1'b0, 1'b0, 0, 0));
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #2;
      bus0.enable = $urandom_range(0, 7) != 0;
      bus1.enable = $urandom_range(0, 3) != 0;
      if (i == 2000) rst_n = 1'b0;
      if (i == 2002) rst_n = 1'b1;
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
